// File: rtl/ram_bist_master_pkg.sv
// Shared definitions for the RAM BIST initiator: default geometry and FSM states.
package ram_bist_master_pkg;

    localparam int unsigned BIST_AW = 4;
    localparam int unsigned BIST_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CMP,
        DONE
    } bist_state_t;

endpackage

// File: rtl/ram_bist_master_addr_seq.sv
// Address sequencer for the BIST write and read sweeps; holds at N-1 rather than wrapping.
module bist_addr_seq #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    assign last = &addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_bist_master.sv
// Writes a seed-derived pattern to every RAM location, reads it back and reports
// pass/fail, mismatch count and first failing address.
module ram_bist_master
    import ram_bist_master_pkg::*;
#(
    parameter int AW = BIST_AW,
    parameter int DW = BIST_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] fail_addr
);

    bist_state_t   state;
    bist_state_t   state_next;
    logic [DW-1:0] seed_q;
    logic [DW-1:0] seed_next;
    logic          we_next;
    logic [DW-1:0] wdata_next;
    logic [AW:0]   err_next;
    logic [AW-1:0] fail_next;
    logic          pass_next;
    logic          addr_clr;
    logic          addr_en;
    logic          addr_last;
    logic          mismatch;

    // Address zero-extended (or truncated) to DW, XORed with the seed.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
        logic [DW-1:0] ext;
        ext = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (i < DW) ext[i] = a[i];
        end
        return ext ^ s;
    endfunction

    bist_addr_seq #(
        .AW(AW)
    ) u_addr_seq (
        .clk (clk),
        .rst (rst),
        .clr (addr_clr),
        .en  (addr_en),
        .addr(ram_addr),
        .last(addr_last)
    );

    assign mismatch = (ram_rdata != pattern(ram_addr, seed_q));
    assign busy     = (state == WRITE) || (state == READ) || (state == CMP);
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        seed_next  = seed_q;
        we_next    = 1'b0;
        wdata_next = '0;
        err_next   = err_cnt;
        fail_next  = fail_addr;
        pass_next  = pass;
        addr_clr   = 1'b0;
        addr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    seed_next  = seed;
                    err_next   = '0;
                    fail_next  = '0;
                    pass_next  = 1'b0;
                    addr_clr   = 1'b1;
                    we_next    = 1'b1;
                    wdata_next = pattern('0, seed);
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Write data is registered alongside the address, so it is
                // computed from the address the counter is about to hold.
                if (addr_last) begin
                    addr_clr   = 1'b1;
                    state_next = READ;
                end else begin
                    addr_en    = 1'b1;
                    we_next    = 1'b1;
                    wdata_next = pattern(ram_addr + 1'b1, seed_q);
                end
            end
            READ: begin
                state_next = CMP;
            end
            CMP: begin
                if (mismatch) begin
                    err_next = err_cnt + 1'b1;
                    if (err_cnt == '0) fail_next = ram_addr;
                end
                if (addr_last) begin
                    pass_next  = (err_next == '0);
                    state_next = DONE;
                end else begin
                    addr_en    = 1'b1;
                    state_next = READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            seed_q    <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            seed_q    <= seed_next;
            ram_we    <= we_next;
            ram_wdata <= wdata_next;
            err_cnt   <= err_next;
            fail_addr <= fail_next;
            pass      <= pass_next;
        end
    end

endmodule
